pwm_capture: RTL and testbench

Measures an incoming PWM waveform, the receive-side counterpart of the `pwm` generator used by the LED fade path. Each complete period produces one `high_time`/`period` sample with a one-cycle strobe. A stuck-line detector flags a signal that has stopped toggling. Used for loopback checking of the on-board PWM, and for reading an external PWM input into the fade logic.

---
 rtl/pwm_capture_if.sv | 44 ++++
 rtl/pwm_capture.sv | 229 ++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// -----------------------------------------------------------------------------
// pwm_capture_if
//   Result bundle of the PWM capture block: the latest high-time / period
//   measurement with its one-cycle update strobe, plus the stuck-line flags.
//
//   Parameters
//     TIMEOUT       timeout in clk cycles; sets the count width
//   Signals (driven by the master side)
//     high_time     [CW] high cycles in the last complete period
//     period        [CW] cycles between the last two accepted rising edges
//     sample_valid       one-cycle pulse when high_time/period update
//     stuck              no accepted rising edge for TIMEOUT cycles
//     stuck_level        line level while stuck, 0 otherwise
//   Modports
//     master        producer (pwm_capture)
//     slave         consumer
// -----------------------------------------------------------------------------
interface pwm_capture_if #(
    parameter int TIMEOUT = 2400
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] high_time;
    logic [CW-1:0] period;
    logic          sample_valid;
    logic          stuck;
    logic          stuck_level;

    modport master (
        output high_time,
        output period,
        output sample_valid,
        output stuck,
        output stuck_level
    );

    modport slave (
        input high_time,
        input period,
        input sample_valid,
        input stuck,
        input stuck_level
    );
endinterface

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Measures an incoming PWM waveform. Every complete period yields one
//   high_time/period sample with a one-cycle strobe; a line that stops
//   producing rising edges for TIMEOUT cycles is flagged as stuck.
//
//   Optional feature macro: PWM_CAPTURE_GLITCH_FILTER_EN
//     defined   - glitch filter between synchronizer and edge detect; the
//                 level only follows the line after FILTER_LEN stable cycles
//     undefined - level is the synchronizer output directly
//
//   Parameters
//     PWM_INTERVAL  nominal period in clk cycles
//     TIMEOUT       cycles without an accepted rise before stuck asserts
//     FILTER_LEN    glitch-filter length (filter build only)
//   Ports
//     clk           12 MHz system clock
//     rst_n         synchronous active-low reset
//     pwm_in        PWM input, asynchronous to clk
//     cap           pwm_capture_if.master result bundle
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for the line to be low before arming
// ARMED | waiting for the first rising edge; nothing measured yet
// HIGH  | inside the high phase of a period
// LOW   | inside the low phase; next rise closes the period
// -----------------------------------------------------------------------------
module pwm_capture #(
    parameter int PWM_INTERVAL = 1200,
    parameter int TIMEOUT      = 2 * PWM_INTERVAL,
    parameter int FILTER_LEN   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    pwm_capture_if.master cap
);
    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (FILTER_LEN < 1 || TIMEOUT < PWM_INTERVAL) begin : g_param_check
        $error("pwm_capture: FILTER_LEN must be >= 1 and TIMEOUT >= PWM_INTERVAL");
    end

    // ------------------------------------------------------------------
    // Front end: synchronizer, optional filter, edge detect
    // ------------------------------------------------------------------
    logic s1_q;
    logic s2_q;
    logic lvl;
    logic lvl_dly_q;
    logic rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FW        = $clog2(FILTER_LEN + 1);
    localparam int PRIME_LEN = 2 + FILTER_LEN;

    logic [FW-1:0] filt_cnt_q;
    logic          lvl_q;

    // Counts consecutive cycles where s2 disagrees with the filtered level;
    // any agreeing cycle restarts the count, so short pulses never get through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_cnt_q <= '0;
            lvl_q      <= 1'b0;
        end else if (s2_q != lvl_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                lvl_q      <= s2_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end else begin
            filt_cnt_q <= '0;
        end
    end

    assign lvl = lvl_q;
`else
    localparam int PRIME_LEN = 2;

    assign lvl = s2_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_dly_q <= 1'b0;
        end else begin
            lvl_dly_q <= lvl;
        end
    end

    assign rise = lvl & ~lvl_dly_q;

    // The front-end flops come out of reset at 0, so for the first few cycles
    // lvl reads low even if the line is high. IDLE must not treat that reset
    // artefact as a real low level, or a line high at reset release would arm
    // immediately and produce a truncated first period.
    localparam int PW = $clog2(PRIME_LEN + 1);

    logic [PW-1:0] prime_cnt_q;
    logic          primed;

    assign primed = (prime_cnt_q == PW'(PRIME_LEN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prime_cnt_q <= '0;
        end else if (!primed) begin
            prime_cnt_q <= prime_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIGH,
        LOW
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_p_q;
    logic [CW-1:0] cnt_h_q;
    logic [CW-1:0] high_time_q;
    logic [CW-1:0] period_q;
    logic          sample_valid_q;
    logic          stuck_q;
    logic          stuck_level_q;

    logic [CW-1:0] cnt_p_inc;
    logic          timeout;

    assign cnt_p_inc = (cnt_p_q == CNT_MAX) ? CNT_MAX : cnt_p_q + CNT_ONE;
    // A rise in the same cycle as the timeout always wins.
    assign timeout   = (cnt_p_q == CNT_MAX) && !rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_p_q        <= '0;
            cnt_h_q        <= '0;
            high_time_q    <= '0;
            period_q       <= '0;
            sample_valid_q <= 1'b0;
            stuck_q        <= 1'b0;
            stuck_level_q  <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            cnt_p_q        <= cnt_p_inc;

            if (stuck_q || timeout) begin
                stuck_level_q <= lvl;
            end
            if (timeout) begin
                stuck_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (primed && !lvl) begin
                        state_q <= ARMED;
                        cnt_p_q <= '0;
                    end
                end

                ARMED: begin
                    if (rise) begin
                        state_q       <= HIGH;
                        cnt_p_q       <= CNT_ONE;
                        cnt_h_q       <= CNT_ONE;
                        stuck_q       <= 1'b0;
                        stuck_level_q <= 1'b0;
                    end else if (timeout) begin
                        state_q <= IDLE;
                    end
                end

                HIGH: begin
                    if (timeout) begin
                        state_q <= IDLE;
                    end else if (!lvl) begin
                        state_q <= LOW;
                    end else begin
                        cnt_h_q <= cnt_h_q + CNT_ONE;
                    end
                end

                LOW: begin
                    if (rise) begin
                        state_q        <= HIGH;
                        period_q       <= cnt_p_q;
                        high_time_q    <= cnt_h_q;
                        sample_valid_q <= 1'b1;
                        cnt_p_q        <= CNT_ONE;
                        cnt_h_q        <= CNT_ONE;
                    end else if (timeout) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cap.high_time    = high_time_q;
    assign cap.period       = period_q;
    assign cap.sample_valid = sample_valid_q;
    assign cap.stuck        = stuck_q;
    assign cap.stuck_level  = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//   Directed bench for pwm_capture: clean PWM, stuck-low timeout and recovery,
//   extreme duty cycles, reset in the middle of a high phase with the line
//   still high, and a short glitch inside a high phase.
//   Follows PWM_CAPTURE_GLITCH_FILTER_EN to pick the matching expectations.
// -----------------------------------------------------------------------------
module tb_pwm_capture;
    localparam int TIMEOUT = 2400;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FLT = 4;
    localparam int EH1 = 4;
    localparam int EP1 = 8;
    localparam int EH2 = 1196;
`else
    localparam int FLT = 0;
    localparam int EH1 = 1;
    localparam int EP1 = 2;
    localparam int EH2 = 1199;
`endif
    localparam int LAT = 3 + FLT;

    logic clk = 1'b0;
    logic rst_n;
    logic pwm_in;

    pwm_capture_if #(.TIMEOUT(TIMEOUT)) cap_if ();

    pwm_capture #(
        .PWM_INTERVAL(1200),
        .TIMEOUT     (TIMEOUT),
        .FILTER_LEN  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_in(pwm_in),
        .cap   (cap_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned h;
        int unsigned p;
        int unsigned c;
    } samp_t;

    samp_t       got_q[$];
    samp_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    logic        rst_seen = 1'b0;
    int unsigned prev_h   = 0;
    int unsigned prev_p   = 0;
    logic        prev_sv  = 1'b0;
    int          stab_err = 0;
    int          pulse_err = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    // Sample collector plus output-stability and pulse-width watchers.
    always @(negedge clk) begin
        if (cap_if.sample_valid === 1'b1) begin
            got_q.push_back('{h: 32'(cap_if.high_time), p: 32'(cap_if.period), c: cyc});
        end
        if (rst_seen && cap_if.sample_valid !== 1'b1 &&
            (32'(cap_if.high_time) != prev_h || 32'(cap_if.period) != prev_p)) begin
            stab_err <= stab_err + 1;
        end
        if (prev_sv && cap_if.sample_valid === 1'b1) begin
            pulse_err <= pulse_err + 1;
        end
        prev_h  <= 32'(cap_if.high_time);
        prev_p  <= 32'(cap_if.period);
        prev_sv <= (cap_if.sample_valid === 1'b1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lv, input int n);
        pwm_in = lv;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic period_pwm(input int h, input int p);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_exp(input int unsigned eh, input int unsigned ep);
        exp_q.push_back('{h: eh, p: ep, c: 0});
    endtask

    task automatic expect_samples(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_high%0d", tag, i), got_q[i].h, exp_q[i].h);
            check_eq($sformatf("%s_period%0d", tag, i), got_q[i].p, exp_q[i].p);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_high_time"}, 32'(cap_if.high_time), 0);
        check_eq({tag, "_period"}, 32'(cap_if.period), 0);
        check_eq({tag, "_sample_valid"}, 32'(cap_if.sample_valid), 0);
        check_eq({tag, "_stuck"}, 32'(cap_if.stuck), 0);
        check_eq({tag, "_stuck_level"}, 32'(cap_if.stuck_level), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rise_cyc;
        int unsigned last_c;
        int unsigned stuck_c;
        logic        found;

        rise_cyc = 0;
        last_c   = 0;
        stuck_c  = 0;
        found    = 1'b0;
        rst_n    = 1'b0;
        pwm_in   = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_outputs_zero("reset");
        rst_n = 1'b1;
        hold(1'b0, 20);

        // Clean 300/1200 PWM: first rise arms, each later rise closes a period.
        for (int i = 0; i < 4; i++) begin
            if (i == 1) rise_cyc = cyc;
            period_pwm(300, 1200);
        end
        hold(1'b1, 300);
        repeat (4) push_exp(300, 1200);
        if (got_q.size() >= 2) begin
            check_eq("clean_latency", got_q[0].c - rise_cyc, LAT);
            check_eq("clean_spacing", got_q[1].c - got_q[0].c, 1200);
        end else begin
            check_eq("clean_early_samples", got_q.size(), 2);
        end
        if (got_q.size() > 0) last_c = got_q[$].c;
        expect_samples("clean");

        // Line stays low: stuck must assert exactly TIMEOUT cycles after the last sample.
        pwm_in = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (cap_if.stuck === 1'b1) begin
                found   = 1'b1;
                stuck_c = cyc;
            end
        end
        @(posedge clk);
        #1;
        check_eq("stuck_seen", found, 1);
        check_eq("stuck_delay", stuck_c - last_c, TIMEOUT);
        check_eq("stuck_level_low", 32'(cap_if.stuck_level), 0);
        check_eq("stuck_hold_high_time", 32'(cap_if.high_time), 300);
        check_eq("stuck_hold_period", 32'(cap_if.period), 1200);

        // Next rise clears stuck without a sample; the following rise samples.
        hold(1'b1, 10);
        check_eq("stuck_cleared", 32'(cap_if.stuck), 0);
        check_eq("stuck_level_cleared", 32'(cap_if.stuck_level), 0);
        check_eq("no_sample_on_rearm", got_q.size(), 0);
        hold(1'b1, 590);
        hold(1'b0, 600);

        // Extreme duty cycles.
        push_exp(600, 1200);
        repeat (3) push_exp(EH1, EP1);
        repeat (2) push_exp(EH2, 1200);
        repeat (3) period_pwm(EH1, EP1);
        repeat (2) period_pwm(EH2, 1200);
        hold(1'b1, 50);
        expect_samples("extreme");

        // Reset inside a high phase, line still high at release.
        pulse_reset();
        check_outputs_zero("rst_mid");
        hold(1'b1, 100);
        hold(1'b0, 600);
        check_eq("rst_no_stale_sample", got_q.size(), 0);
        repeat (2) period_pwm(600, 1200);
        hold(1'b1, 50);
        repeat (2) push_exp(600, 1200);
        expect_samples("rst_high");

        // 2-cycle low glitch inside a 300-cycle high phase.
        hold(1'b0, 20);
        pulse_reset();
        hold(1'b0, 20);
        repeat (2) begin
            hold(1'b1, 100);
            hold(1'b0, 2);
            hold(1'b1, 198);
            hold(1'b0, 900);
        end
        hold(1'b1, 50);
        hold(1'b0, 10);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        repeat (2) push_exp(300, 1200);
`else
        repeat (2) begin
            push_exp(100, 102);
            push_exp(198, 1098);
        end
`endif
        expect_samples("glitch");

        check_eq("outputs_stable_between_samples", stab_err, 0);
        check_eq("sample_valid_single_cycle", pulse_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
